// File: rtl/buffer_sched_pkg.sv
// Shared definitions for the buffer scheduler.
// Holds the default geometry of the buffer, the encoded grant values
// reported by the arbiter, and the requester slot indices used for the
// round-robin "last winner" state.
package buffer_sched_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DW_DEF       = 16;

    // Encoded grant
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_W0   = 2'd1;
    localparam logic [1:0] GNT_W1   = 2'd2;
    localparam logic [1:0] GNT_R    = 2'd3;

    // Requester slot indices, in round-robin order W0 -> W1 -> R -> W0
    localparam logic [1:0] IDX_W0 = 2'd0;
    localparam logic [1:0] IDX_W1 = 2'd1;
    localparam logic [1:0] IDX_R  = 2'd2;

endpackage

// File: rtl/buffer_sched_ctrl_rr_arb3.sv
// Three-way round-robin arbiter.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   elig      - eligible requests, bit0 = W0, bit1 = W1, bit2 = R
//   gnt_oh    - one-hot grant (same bit order), combinational
//   gnt_enc   - encoded grant (GNT_NONE/GNT_W0/GNT_W1/GNT_R)
// The search begins at the slot after the last winner; the last winner
// only moves on a cycle that actually grants.
module rr_arb3
    import buffer_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] elig,
    output logic [2:0] gnt_oh,
    output logic [1:0] gnt_enc
);

    logic [1:0] last;
    logic [1:0] s0, s1, s2;

    always_comb begin
        // Priority order for this cycle, starting after the last winner
        s0 = IDX_W0;
        s1 = IDX_W1;
        s2 = IDX_R;
        case (last)
            IDX_W0: begin s0 = IDX_W1; s1 = IDX_R;  s2 = IDX_W0; end
            IDX_W1: begin s0 = IDX_R;  s1 = IDX_W0; s2 = IDX_W1; end
            default: ;
        endcase

        gnt_oh = 3'b000;
        if (elig[s0])      gnt_oh[s0] = 1'b1;
        else if (elig[s1]) gnt_oh[s1] = 1'b1;
        else if (elig[s2]) gnt_oh[s2] = 1'b1;

        if (gnt_oh[0])      gnt_enc = GNT_W0;
        else if (gnt_oh[1]) gnt_enc = GNT_W1;
        else if (gnt_oh[2]) gnt_enc = GNT_R;
        else                gnt_enc = GNT_NONE;
    end

    // Reset to R so that W0 is searched first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= IDX_R;
        end else if (gnt_oh != 3'b000) begin
            if (gnt_oh[0])      last <= IDX_W0;
            else if (gnt_oh[1]) last <= IDX_W1;
            else                last <= IDX_R;
        end
    end

endmodule

// File: rtl/buffer_sched_ctrl.sv
// Scheduler and FIFO pointer controller for a single-access-per-cycle buffer.
// Arbitrates two writers and one reader round-robin, drives the buffer's
// strobes/addresses/write data and tracks occupancy.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   wr_req0/1, wr_data0/1       - write requesters (held until granted)
//   wr_gnt0/1                   - combinational write grants
//   rd_req, rd_gnt              - read request / combinational grant
//   rd_valid, rd_data           - read data, valid the cycle after rd_gnt
//   mem_w, mem_r                - buffer strobes (never both high)
//   mem_w_addr, mem_r_addr      - buffer addresses (current pointers)
//   mem_data_in, mem_data_out   - buffer write data / registered read data
//   count, full, empty          - occupancy and registered flags
module buffer_sched_ctrl
    import buffer_sched_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int DW       = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req0,
    input  logic                wr_req1,
    input  logic [DW-1:0]       wr_data0,
    input  logic [DW-1:0]       wr_data1,
    output logic                wr_gnt0,
    output logic                wr_gnt1,
    input  logic                rd_req,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic                mem_w,
    output logic                mem_r,
    output logic [ADDRSIZE-1:0] mem_w_addr,
    output logic [ADDRSIZE-1:0] mem_r_addr,
    output logic [DW-1:0]       mem_data_in,
    input  logic [DW-1:0]       mem_data_out,
    output logic [ADDRSIZE:0]   count,
    output logic                full,
    output logic                empty
);

    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] ONE   = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] wptr, rptr, count_nxt;
    logic [2:0]        elig, gnt_oh;
    logic [1:0]        gnt_enc;
    logic              rd_vld_p1;

    // Gating with rst keeps every grant and strobe low while in reset
    assign elig = {rd_req & ~empty, wr_req1 & ~full, wr_req0 & ~full} & {3{rst}};

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .elig    (elig),
        .gnt_oh  (gnt_oh),
        .gnt_enc (gnt_enc)
    );

    assign wr_gnt0 = gnt_oh[0];
    assign wr_gnt1 = gnt_oh[1];
    assign rd_gnt  = gnt_oh[2];

    assign mem_w      = (gnt_enc == GNT_W0) || (gnt_enc == GNT_W1);
    assign mem_r      = (gnt_enc == GNT_R);
    assign mem_w_addr = wptr[ADDRSIZE-1:0];
    assign mem_r_addr = rptr[ADDRSIZE-1:0];
    assign rd_data    = mem_data_out;
    assign rd_valid   = rd_vld_p1;

    always_comb begin
        mem_data_in = '0;
        count_nxt   = count;
        case (gnt_enc)
            GNT_W0: begin mem_data_in = wr_data0; count_nxt = count + ONE; end
            GNT_W1: begin mem_data_in = wr_data1; count_nxt = count + ONE; end
            GNT_R:  count_nxt = count - ONE;
            default: ;
        endcase
    end

    // ---- stage p0 -> p1: pointers, occupancy, flags, read-valid ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_vld_p1 <= 1'b0;
        end else begin
            if (mem_w) wptr <= wptr + ONE;
            if (mem_r) rptr <= rptr + ONE;
            count     <= count_nxt;
            full      <= (count_nxt == DEPTH);
            empty     <= (count_nxt == '0);
            rd_vld_p1 <= mem_r;
        end
    end

endmodule

// File: doc/buffer_sched_ctrl.md
# buffer_sched_ctrl

Scheduler and pointer controller for the 16-bit single-port-per-cycle memory buffer. It arbitrates two write requesters and one read requester round-robin. It generates the buffer's `w`/`r` strobes and addresses, and maintains FIFO pointers, occupancy and full/empty flags. It sits between the producers/consumer and the buffer instance. The buffer must never see `w` and `r` together, because `w` would silently swallow the read.

## Interface
- `ADDRSIZE`, default 4: buffer address width; depth = 2^ADDRSIZE.
- `DW`, default 16: data width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_req0`, `wr_req1` in 1: write requests; held with data until granted.
- `wr_data0`, `wr_data1` in DW: write data.
- `wr_gnt0`, `wr_gnt1` out 1: combinational grant; transfer occurs on a cycle with req & gnt.
- `rd_req` in 1: read request; held until granted.
- `rd_gnt` out 1: combinational read grant.
- `rd_valid` out 1: read data valid, one cycle after `rd_gnt`.
- `rd_data` out DW: equals `mem_data_out`, meaningful while `rd_valid`.
- `mem_w`, `mem_r` out 1: buffer write/read strobes.
- `mem_w_addr`, `mem_r_addr` out ADDRSIZE: buffer addresses.
- `mem_data_in` out DW: buffer write data (muxed winner data).
- `mem_data_out` in DW: buffer registered read data.
- `count` out ADDRSIZE+1: occupancy, 0..depth.
- `full`, `empty` out 1: registered flags.

## Operation
- Eligibility:
  - W0 = `wr_req0 & ~full`.
  - W1 = `wr_req1 & ~full`.
  - R = `rd_req & ~empty`.
- At most one grant per cycle. Round-robin over the order W0 → W1 → R → W0. The search starts at the slot after `last`. `last` updates only on a cycle with a grant.
- Write grant:
  - `mem_w=1`, `mem_w_addr=wptr[ADDRSIZE-1:0]`, `mem_data_in` = winner data.
  - `wptr` increments at the clock edge.
- Read grant:
  - `mem_r=1`, `mem_r_addr=rptr[ADDRSIZE-1:0]`.
  - `rptr` increments at the edge; `rd_valid` is registered to 1 for the next cycle.
- No grant: `mem_w=mem_r=0`, `mem_data_in=0`. Addresses still show the current pointers.
- `wptr`/`rptr` are ADDRSIZE+1 bits and wrap naturally at 2·depth. Memory addresses wrap at depth.
- `count` +1 on a write grant, −1 on a read grant. It never changes by both, since grants are exclusive.
- `full = (count == depth)`, `empty = (count == 0)`. Both are registered from the next-count value, so they are exact in the same cycle as `count`.
- When full, writers are ineligible and the reader wins if requesting. When empty, the reader is ineligible.
- Reset values:
  - Pointers, `count`, `rd_valid`: 0.
  - `empty=1`, `full=0`.
  - `last=R`, so W0 has first priority.
  - All grants and strobes are 0 during reset.
- Reset mid-operation: all state clears immediately. An in-flight `rd_valid` is dropped. Memory contents are not cleared.
- Invariant: `mem_w & mem_r` is never 1.

## Timing
- Grant latency: 0 cycles. The grant is combinational from the req inputs and registered state in the same cycle T.
- Write data is captured by the buffer at the end of cycle T.
- Read: grant in T, data valid and `rd_valid=1` in T+1. Reads can issue back-to-back, giving one word per cycle.
- Write then read of the same word: write in T, read granted no earlier than T+1 (`empty` deasserts after T), data in T+2.
- Under contention, each of three continuously eligible requesters is granted once every 3 cycles.

## Structure
- Shared package `buffer_sched_pkg`:
  - Grant encoding constants: `GNT_NONE`, `GNT_W0`, `GNT_W1`, `GNT_R` (2-bit).
  - Default `ADDRSIZE`/`DW`.
- Sub-module `rr_arb3`: 3-request round-robin arbiter. Inputs are the eligible vector, `last` state and clk/rst. Outputs are a one-hot grant and the encoded grant.
- The top level holds the pointers, count, flags, read-valid register and mem muxing.

## Test plan
- Reset, then idle: `empty=1`, `full=0`, `count=0`, no strobes. Assert `rd_req` alone → `rd_gnt` stays 0 indefinitely.
- `wr_req0` writes 0x1111, 0x2222; then `rd_req` → `mem_w_addr` 0 then 1. Reads return 0x1111 then 0x2222 with `rd_valid` one cycle after each `rd_gnt`. `empty` returns to 1.
- Fill with 16 writes (0x0000..0x000F): `full=1`, `count=16` after the 16th. A 17th `wr_req1` is not granted. A read grant frees a slot; the next write goes to address 0 (wrap). Reads continue in order, with the 17th write's data read last.
- All three requesting continuously with 4 words stored: grant sequence is W0, W1, R, W0, W1, R. `mem_w & mem_r` is never 1.
- Pull `rst` low the cycle after a `rd_gnt` → `rd_valid=0` immediately, `count=0`, `empty=1`. After release, W0 is granted first.
- Read and write arrive together on an almost-full buffer (`count=15`): round-robin order is honored and `count` stays within 14..16 with flags exact each cycle.
